// File: rtl/query_pkg.sv
// Shared types and defaults for the query row double buffer and its reader.
package query_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 11;
    localparam int unsigned DEF_ADDR_WIDTH = 7;
    localparam int unsigned DEF_ROW_LEN    = 128;

    typedef logic bank_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_RELEASE
    } reader_state_e;

endpackage

// File: rtl/reader_skid_fifo.sv
// Synchronous FIFO that absorbs RAM read latency ahead of the downstream handshake.
module reader_skid_fifo
    import query_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DEF_DATA_WIDTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_i) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_i, rd_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/query_row_reader.sv
// Streams a full query-row bank out of RAM in address order, then hands the bank back.
module query_row_reader
    import query_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned ROW_LEN      = DEF_ROW_LEN,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned SKID_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fsm_enable,
    input  logic                  row_valid,
    input  bank_idx_t             row_bank,
    output logic                  row_release,
    output logic                  ren,
    output logic [ADDR_WIDTH-1:0] radr,
    output bank_idx_t             rbank,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0] receiver_data,
    input  logic                  receiver_full_n,
    output logic                  receiver_enq,
    output logic                  busy
);

    localparam int unsigned CNT_W      = $clog2(ROW_LEN + 1);
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int unsigned CRED_W     = $clog2(SKID_DEPTH + READ_LATENCY + 2);

    reader_state_e           state_q, state_d;
    bank_idx_t               rbank_q, rbank_d;
    logic [CNT_W-1:0]        issued_q, issued_d;
    logic [CNT_W-1:0]        delivered_q, delivered_d;
    logic [ADDR_WIDTH-1:0]   radr_q, radr_d;
    logic                    ren_q, ren_d;
    logic                    release_q, release_d;
    logic                    busy_q, busy_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;

    logic                    skid_wr;
    logic [SKID_CNT_W-1:0]   skid_count;
    logic                    skid_full;
    logic                    skid_empty;
    logic [CRED_W-1:0]       inflight;
    logic [CRED_W-1:0]       credit_used;
    logic                    credit_ok;

    assign skid_wr      = pipe_q[READ_LATENCY-1];
    assign receiver_enq = !skid_empty && receiver_full_n;
    assign pipe_d       = READ_LATENCY'({pipe_q, ren_q});

    reader_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (skid_wr),
        .wr_data_i (ram_data),
        .rd_i      (receiver_enq),
        .head_o    (receiver_data),
        .count_o   (skid_count),
        .full_o    (skid_full),
        .empty_o   (skid_empty)
    );

    // Slots claimed next cycle if nothing new issues: reads in flight plus skid, less this cycle's pop.
    always_comb begin
        inflight = CRED_W'(ren_q);
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            inflight = inflight + CRED_W'(pipe_q[i]);
        end
        credit_used = inflight + CRED_W'(skid_count) - CRED_W'(receiver_enq);
        credit_ok   = (credit_used < CRED_W'(SKID_DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        rbank_d     = rbank_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        radr_d      = radr_q;
        ren_d       = 1'b0;
        release_d   = 1'b0;
        if (receiver_enq) delivered_d = delivered_q + CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (row_valid && fsm_enable) begin
                    state_d     = ST_READ;
                    rbank_d     = row_bank;
                    issued_d    = '0;
                    delivered_d = '0;
                end
            end
            ST_READ: begin
                if (fsm_enable && (issued_q < CNT_W'(ROW_LEN)) && credit_ok) begin
                    ren_d    = 1'b1;
                    radr_d   = ADDR_WIDTH'(issued_q);
                    issued_d = issued_q + CNT_W'(1);
                end
                if (issued_d == CNT_W'(ROW_LEN)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Release is raised together with the state change so it follows the last word directly.
                if (delivered_d == CNT_W'(ROW_LEN)) begin
                    state_d   = ST_RELEASE;
                    release_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rbank_q     <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            radr_q      <= '0;
            ren_q       <= 1'b0;
            release_q   <= 1'b0;
            busy_q      <= 1'b0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            rbank_q     <= rbank_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            radr_q      <= radr_d;
            ren_q       <= ren_d;
            release_q   <= release_d;
            busy_q      <= busy_d;
            pipe_q      <= pipe_d;
        end
    end

    assign ren         = ren_q;
    assign radr        = radr_q;
    assign rbank       = rbank_q;
    assign row_release = release_q;
    assign busy        = busy_q;

    a_skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(skid_wr && skid_full && !receiver_enq));

endmodule

// File: tb/tb_query_row_reader.sv
// Self-checking bench for query_row_reader: default config plus a one-word row config.
module tb_query_row_reader;

    localparam int unsigned DW  = 11;
    localparam int unsigned AW  = 7;
    localparam int unsigned RL  = 128;
    localparam int unsigned LAT = 2;
    localparam int unsigned SD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    logic          en, row_valid, row_bank, full_n;
    logic [DW-1:0] ram_data;
    logic          row_release, ren, rbank, receiver_enq, busy;
    logic [AW-1:0] radr;
    logic [DW-1:0] receiver_data;

    logic          en2, rv2, rb2, fn2;
    logic [DW-1:0] rd2;
    logic          rel2, ren2, rbank2, enq2, busy2;
    logic [AW-1:0] radr2;
    logic [DW-1:0] rdata2;

    query_row_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_LEN(RL), .READ_LATENCY(LAT), .SKID_DEPTH(SD)
    ) dut (
        .clk(clk), .rst(rst), .fsm_enable(en), .row_valid(row_valid), .row_bank(row_bank),
        .row_release(row_release), .ren(ren), .radr(radr), .rbank(rbank), .ram_data(ram_data),
        .receiver_data(receiver_data), .receiver_full_n(full_n), .receiver_enq(receiver_enq),
        .busy(busy)
    );

    query_row_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_LEN(1), .READ_LATENCY(1), .SKID_DEPTH(2)
    ) dut_small (
        .clk(clk), .rst(rst), .fsm_enable(en2), .row_valid(rv2), .row_bank(rb2),
        .row_release(rel2), .ren(ren2), .radr(radr2), .rbank(rbank2), .ram_data(rd2),
        .receiver_data(rdata2), .receiver_full_n(fn2), .receiver_enq(enq2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // RAM contents: bank 0 holds addr, bank 1 holds 1000+addr
    logic [DW-1:0] mem [2][RL];
    logic          hv [8];
    logic [DW-1:0] hd [8];
    logic          r2_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) hv[i] = 1'b0;
            ram_data = 11'h555;
        end else begin
            hv[cyc % 8] = ren;
            hd[cyc % 8] = mem[rbank][radr];
            ram_data = hv[(cyc + 6) % 8] ? hd[(cyc + 6) % 8] : 11'h555;
        end
        rd2 = r2_prev ? 11'h2A5 : 11'h0F0;
        r2_prev = ren2 && !rst;
    end

    // Behavioural model state for the default-config instance
    bit      active = 1'b0;
    bit      cur_bank = 1'b0;
    bit      prev_en = 1'b0;
    bit      exp_enq, exp_rel;
    int      n_ren = 0, n_enq = 0, enq_start, landed, outst;
    int      cum [8];
    int      first_ren_cyc, first_enq_cyc, last_enq_cyc, max_out, first_radr;
    int      first_data, last_data;
    int      n_release = 0;
    int      last_rel_bank = -1;
    bit      bp_mode = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
            prev_en = 1'b0;
            n_ren = 0;
            n_enq = 0;
            for (int i = 0; i < 8; i++) cum[i] = 0;
        end else begin
            chk("busy", busy, active);
            // A word is available once its read is LAT+1 cycles old.
            landed  = cum[(cyc + 8 - LAT - 1) % 8];
            exp_enq = full_n && (landed > n_enq);
            chk("enq", receiver_enq, exp_enq);
            enq_start = n_enq;
            if (receiver_enq) begin
                chk("data", receiver_data, (n_enq < RL) ? mem[cur_bank][n_enq] : 11'h7FF);
                if (n_enq == 0) begin
                    first_enq_cyc = cyc;
                    first_data = receiver_data;
                end
                last_data = receiver_data;
                last_enq_cyc = cyc;
                n_enq++;
            end
            if (ren) begin
                chk("ren_legal", active && prev_en && (n_ren < RL), 1);
                chk("radr", radr, n_ren);
                chk("rbank", rbank, cur_bank);
                if (n_ren == 0) begin
                    first_ren_cyc = cyc;
                    first_radr = radr;
                end
                n_ren++;
                outst = n_ren - enq_start;
                chk("credit", outst <= SD, 1);
                if (outst > max_out) max_out = outst;
            end
            cum[cyc % 8] = n_ren;
            exp_rel = active && (n_enq == RL) && (last_enq_cyc == cyc - 1);
            chk("release", row_release, exp_rel);
            if (row_release) begin
                chk("release_bank", rbank, cur_bank);
                n_release++;
                last_rel_bank = rbank;
            end
            if (exp_rel) begin
                active = 1'b0;
            end else if (!active && row_valid && en) begin
                active = 1'b1;
                cur_bank = row_bank;
                n_ren = 0;
                n_enq = 0;
                max_out = 0;
                first_ren_cyc = -1;
                first_enq_cyc = -1;
                last_enq_cyc = -100;
                for (int i = 0; i < 8; i++) cum[i] = 0;
            end
            prev_en = en;
        end
    end

    always @(posedge clk) begin
        #1;
        full_n = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_row(input bit b);
        int k;
        row_valid = 1'b1;
        row_bank = b;
        k = 0;
        while (!busy && k < 20) begin
            tick();
            k++;
        end
        chk("row_start", busy, 1);
        row_valid = 1'b0;
    endtask

    task automatic wait_release(input int budget);
        int k, r0;
        r0 = n_release;
        k = 0;
        while (n_release == r0 && k < budget) begin
            tick();
            k++;
        end
        chk("release_seen", n_release - r0, 1);
    endtask

    int rel_snap, snap1, snap2, k;
    int s_ren_n, s_ren_cyc, s_radr, s_enq_n, s_enq_cyc, s_data, s_rel_n, s_rel_cyc, s_rel_bank;

    initial begin
        for (int a = 0; a < int'(RL); a++) begin
            mem[0][a] = DW'(a);
            mem[1][a] = DW'(1000 + a);
        end
        en = 1'b1; row_valid = 1'b0; row_bank = 1'b0; full_n = 1'b1;
        en2 = 1'b1; rv2 = 1'b0; rb2 = 1'b0; fn2 = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("rst_ren", ren, 0);
        chk("rst_radr", radr, 0);
        chk("rst_rbank", rbank, 0);
        chk("rst_release", row_release, 0);
        chk("rst_enq", receiver_enq, 0);
        chk("rst_data", receiver_data, 0);
        chk("rst_busy", busy, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Full-rate row from bank 0
        start_row(1'b0);
        wait_release(400);
        chk("t1_first_latency", first_enq_cyc - first_ren_cyc, 3);
        chk("t1_last_enq", last_enq_cyc - first_ren_cyc, 130);
        chk("t1_count", n_enq, 128);
        chk("t1_first_data", first_data, 0);
        chk("t1_last_data", last_data, 127);
        chk("t1_rel_bank", last_rel_bank, 0);
        chk("t1_rel_count", n_release, 1);
        chk("t1_max_out", max_out, 4);

        // Bank 1 follows
        start_row(1'b1);
        wait_release(400);
        chk("t2_first_data", first_data, 1000);
        chk("t2_last_data", last_data, 1127);
        chk("t2_rel_bank", last_rel_bank, 1);
        chk("t2_rel_count", n_release, 2);

        // Random backpressure
        bp_mode = 1'b1;
        start_row(1'b0);
        wait_release(3000);
        bp_mode = 1'b0;
        chk("t3_count", n_enq, 128);
        chk("t3_last_data", last_data, 127);
        chk("t3_max_out", max_out, 4);

        // fsm_enable gap once address 40 has issued
        start_row(1'b1);
        k = 0;
        while (n_ren < 41 && k < 500) begin
            tick();
            k++;
        end
        chk("t4_reach40", n_ren >= 41, 1);
        en = 1'b0;
        tick();
        snap1 = n_ren;
        repeat (9) tick();
        snap2 = n_ren;
        en = 1'b1;
        chk("t4_gap_no_ren", snap2 - snap1, 0);
        wait_release(1000);
        chk("t4_count", n_enq, 128);
        chk("t4_last_data", last_data, 1127);

        // Asynchronous reset mid-row
        start_row(1'b1);
        k = 0;
        while (n_enq < 60 && k < 500) begin
            tick();
            k++;
        end
        chk("t5_reach60", n_enq >= 60, 1);
        rel_snap = n_release;
        #1 rst = 1'b1;
        #1;
        chk("t5_ren", ren, 0);
        chk("t5_radr", radr, 0);
        chk("t5_rbank", rbank, 0);
        chk("t5_release", row_release, 0);
        chk("t5_enq", receiver_enq, 0);
        chk("t5_data", receiver_data, 0);
        chk("t5_busy", busy, 0);
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("t5_no_release", n_release, rel_snap);
        start_row(1'b0);
        wait_release(400);
        chk("t5_first_radr", first_radr, 0);
        chk("t5_first_data", first_data, 0);
        chk("t5_count", n_enq, 128);
        chk("t5_rel_bank", last_rel_bank, 0);

        // One-word row, latency 1, two-entry skid
        s_ren_n = 0; s_enq_n = 0; s_rel_n = 0;
        s_ren_cyc = -1; s_enq_cyc = -1; s_rel_cyc = -1; s_radr = -1; s_data = -1; s_rel_bank = -1;
        rv2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy2) rv2 = 1'b0;
            if (ren2) begin
                s_ren_n++;
                s_ren_cyc = cyc;
                s_radr = radr2;
            end
            if (enq2) begin
                s_enq_n++;
                s_enq_cyc = cyc;
                s_data = rdata2;
            end
            if (rel2) begin
                s_rel_n++;
                s_rel_cyc = cyc;
                s_rel_bank = rbank2;
            end
        end
        chk("s_ren_count", s_ren_n, 1);
        chk("s_radr", s_radr, 0);
        chk("s_enq_count", s_enq_n, 1);
        chk("s_enq_latency", s_enq_cyc - s_ren_cyc, 2);
        chk("s_data", s_data, 11'h2A5);
        chk("s_rel_count", s_rel_n, 1);
        chk("s_rel_after_enq", s_rel_cyc - s_enq_cyc, 1);
        chk("s_rel_bank", s_rel_bank, 0);
        chk("s_busy_end", busy2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
